stream_output_arbiter: RTL and testbench

STREAM_OUTPUT_ARBITER -- requirements
Module: stream_output_arbiter

---
 rtl/stream_output_arbiter_if.sv | 41 ++++
 rtl/stream_output_arbiter.sv | 141 ++++++++++++++
 tb/tb_stream_output_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_output_arbiter_if.sv
// Stream bundle shared by the output arbiter and whatever drives it:
// per-input beats with valid/ready, one arbitrated output, debug status.
interface stream_output_arbiter_if #(
  parameter int DATA_WIDTH           = 32,
  parameter int ID_WIDTH             = 4,
  parameter int DEST_WIDTH           = 4,
  parameter int USER_WIDTH           = 4,
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } axis_data_t;

  axis_data_t [CHANNEL_NUMBER-1:0] in;
  logic [CHANNEL_NUMBER-1:0]       in_valid;
  logic [CHANNEL_NUMBER-1:0]       in_ready;
  axis_data_t                      out;
  logic                            out_valid;
  logic                            out_ready;
  logic [CHANNEL_NUMBER_WIDTH-1:0] grant_idx;
  logic                            locked;

  // Producer/consumer side: drives input beats and downstream ready.
  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid, grant_idx, locked
  );

  // Arbiter side.
  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid, grant_idx, locked
  );

endinterface

// File: rtl/stream_output_arbiter.sv
// Packet-granular round-robin arbiter: one input owns the output from grant
// until its TLAST beat is accepted. Accepted beats pass through a 2-entry
// FIFO that keeps draining regardless of the arbitration state.
module stream_output_arbiter #(
  parameter int DATA_WIDTH           = 32,
  parameter int ID_WIDTH             = 4,
  parameter int DEST_WIDTH           = 4,
  parameter int USER_WIDTH           = 4,
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input logic                    clk,
  input logic                    rst,
  stream_output_arbiter_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } axis_data_t;

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef logic [CHANNEL_NUMBER_WIDTH-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(CHANNEL_NUMBER - 1);

  state_t     state_q, state_d;
  idx_t       rr_ptr_q;
  idx_t       grant_idx_q;
  idx_t       pick_idx;
  logic       pick_found;
  logic       accept;
  logic       accept_last;
  logic       pop;
  axis_data_t sel_beat;

  axis_data_t fifo_mem [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] fifo_count_q;
  logic       fifo_has_room;

  logic [CHANNEL_NUMBER-1:0] in_ready_d;
  logic                      locked_d;

  assign fifo_has_room = (fifo_count_q < 2'd2);
  assign sel_beat      = bus.in[grant_idx_q];
  assign accept        = (state_q == LOCKED) && bus.in_valid[grant_idx_q] && fifo_has_room;
  assign accept_last   = accept && sel_beat.tlast;
  assign pop           = (fifo_count_q != 2'd0) && bus.out_ready;

  // Round-robin pick: first valid input at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    // Descending scan so the smallest offset from rr_ptr is written last and wins.
    for (int i = CHANNEL_NUMBER - 1; i >= 0; i--) begin
      int   cand_int;
      idx_t cand;
      cand_int = int'(rr_ptr_q) + i;
      if (cand_int >= CHANNEL_NUMBER) cand_int = cand_int - CHANNEL_NUMBER;
      cand = idx_t'(cand_int);
      if (bus.in_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: lock on a pick, release once TLAST is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found)  state_d = LOCKED;
      LOCKED:  if (accept_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only the granted input sees ready, and only while the FIFO has room.
  always_comb begin
    in_ready_d = '0;
    locked_d   = 1'b0;
    if (state_q == LOCKED) begin
      in_ready_d[grant_idx_q] = fifo_has_room;
      locked_d                = 1'b1;
    end
  end

  // Grant index and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      if (state_q == IDLE && pick_found) grant_idx_q <= pick_idx;
      if (accept_last) rr_ptr_q <= (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + idx_t'(1);
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_count_q <= 2'd0;
    end else begin
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      case ({accept, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
        2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the zeroed count makes stale entries invisible.
    if (accept) fifo_mem[wr_ptr_q] <= sel_beat;
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.locked    = locked_d;
  assign bus.grant_idx = grant_idx_q;
  assign bus.out       = fifo_mem[rd_ptr_q];
  assign bus.out_valid = (fifo_count_q != 2'd0);

endmodule

// File: tb/tb_stream_output_arbiter.sv
// Directed bench for stream_output_arbiter: per-input beat queues feed the
// DUT, a monitor logs output beats and grants, tests compare against
// hand-computed sequences.
module tb_stream_output_arbiter;

  localparam int CN = 5;

  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tid;
    logic [3:0]  tdest;
    logic [3:0]  tuser;
    logic        tlast;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stream_output_arbiter_if #(
    .DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4),
    .CHANNEL_NUMBER(CN), .CHANNEL_NUMBER_WIDTH(3)
  ) bus_i ();

  stream_output_arbiter #(
    .DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4),
    .CHANNEL_NUMBER(CN), .CHANNEL_NUMBER_WIDTH(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t        q [CN][$];
  logic [CN-1:0] hold = '0;
  logic [CN-1:0] acc_pend = '0;
  int           acc_cnt [CN];
  beat_t        obs [$];
  int           obs_cyc [$];
  int           grants [$];
  int           grant_cyc [$];
  logic         prev_locked = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input int ch, input int b, input bit last);
    beat_t r;
    r.tdata = 32'hD000_0000 | 32'(ch << 8) | 32'(b);
    r.tid   = 4'(ch);
    r.tdest = 4'(b);
    r.tuser = 4'(ch + b);
    r.tlast = last;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pkt(input int ch, input int n);
    for (int b = 0; b < n; b++) q[ch].push_back(mk(ch, b, b == n - 1));
  endtask

  task automatic wait_obs(input string tag, input int n, input int budget);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(obs.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < CN; c++) q[c].delete();
    obs.delete();
    obs_cyc.delete();
    grants.delete();
    grant_cyc.delete();
  endtask

  // Source driver and monitor: drive at negedge, sample handshakes 1 ns later.
  initial begin
    for (int c = 0; c < CN; c++) acc_cnt[c] = 0;
    bus_i.in       = '0;
    bus_i.in_valid = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < CN; c++)
        if (acc_pend[c] && q[c].size() > 0) void'(q[c].pop_front());
      for (int c = 0; c < CN; c++) begin
        if (q[c].size() > 0 && !hold[c]) begin
          bus_i.in[c]       = q[c][0];
          bus_i.in_valid[c] = 1'b1;
        end else begin
          bus_i.in[c]       = '0;
          bus_i.in_valid[c] = 1'b0;
        end
      end
      #1;
      for (int c = 0; c < CN; c++) begin
        acc_pend[c] = bus_i.in_valid[c] && bus_i.in_ready[c];
        if (acc_pend[c]) acc_cnt[c]++;
      end
      if (bus_i.out_valid && bus_i.out_ready) begin
        obs.push_back(bus_i.out);
        obs_cyc.push_back(cyc);
      end
      if (bus_i.locked && !prev_locked) begin
        grants.push_back(int'(bus_i.grant_idx));
        grant_cyc.push_back(cyc);
      end
      prev_locked = bus_i.locked;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int k0;
  int base;
  int n;
  int exp_g [6];

  initial begin
    bus_i.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();

    // Reset state while rst is held.
    check("rst_out_valid", 64'(bus_i.out_valid), 64'd0);
    check("rst_locked",    64'(bus_i.locked),    64'd0);
    check("rst_in_ready",  64'(bus_i.in_ready),  64'd0);
    check("rst_grant_idx", 64'(bus_i.grant_idx), 64'd0);
    do_reset();

    // Single requester on input 2, 4-beat packet.
    bus_i.out_ready = 1'b1;
    k0 = cyc;
    push_pkt(2, 4);
    wait_obs("t1_count", 4, 40);
    check("t1_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'd2);
    check("t1_grant_cyc", 64'(grant_cyc.size() > 0 ? grant_cyc[0] - k0 : -1), 64'd1);
    check("t1_first_beat_cyc", 64'(obs_cyc.size() > 0 ? obs_cyc[0] - k0 : -1), 64'd2);
    for (int b = 0; b < 4 && b < obs.size(); b++) begin
      check($sformatf("t1_beat%0d", b), 64'(obs[b]), 64'(mk(2, b, b == 3)));
      check($sformatf("t1_beat%0d_cyc", b), 64'(obs_cyc[b] - obs_cyc[0]), 64'(b));
    end
    step();
    step();
    check("t1_idle_after", 64'(bus_i.locked), 64'd0);
    // rr_ptr is now 3: with inputs 0 and 3 both requesting, 3 wins first.
    push_pkt(0, 1);
    push_pkt(3, 1);
    wait_obs("t1_rr_count", 6, 40);
    check("t1_rr_first",  64'(grants.size() > 1 ? grants[1] : -1), 64'd3);
    check("t1_rr_second", 64'(grants.size() > 2 ? grants[2] : -1), 64'd0);

    // All inputs requesting single-beat packets from reset.
    do_reset();
    bus_i.out_ready = 1'b1;
    for (int c = 0; c < CN; c++) push_pkt(c, 1);
    q[0].push_back(mk(0, 1, 1'b1));
    wait_obs("t2_count", 6, 60);
    exp_g = '{0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 6 && i < grants.size() && i < obs.size(); i++) begin
      check($sformatf("t2_grant%0d", i), 64'(grants[i]), 64'(exp_g[i]));
      check($sformatf("t2_beat%0d", i), 64'(obs[i]), 64'(mk(exp_g[i], (i == 5) ? 1 : 0, 1'b1)));
      if (i > 0) check($sformatf("t2_gap%0d", i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd2);
    end

    // Backpressure: only two beats fit before in_ready drops.
    do_reset();
    bus_i.out_ready = 1'b0;
    base = acc_cnt[1];
    push_pkt(1, 6);
    for (int i = 0; i < 12; i++) step();
    check("t3_accepted", 64'(acc_cnt[1] - base), 64'd2);
    check("t3_in_ready", 64'(bus_i.in_ready), 64'd0);
    check("t3_out_valid", 64'(bus_i.out_valid), 64'd1);
    check("t3_head", 64'(bus_i.out), 64'(mk(1, 0, 1'b0)));
    bus_i.out_ready = 1'b1;
    wait_obs("t3_count", 6, 40);
    for (int b = 0; b < 6 && b < obs.size(); b++)
      check($sformatf("t3_beat%0d", b), 64'(obs[b]), 64'(mk(1, b, b == 5)));

    // Mid-packet stall on input 1 while input 0 waits.
    obs.delete();
    obs_cyc.delete();
    grants.delete();
    grant_cyc.delete();
    base = acc_cnt[1];
    push_pkt(1, 4);
    n = 0;
    while (acc_cnt[1] - base < 2 && n < 30) begin
      step();
      n++;
    end
    check("t4_two_accepted", 64'(acc_cnt[1] - base), 64'd2);
    hold[1] = 1'b1;
    push_pkt(0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_stall%0d_locked", i), 64'(bus_i.locked), 64'd1);
      check($sformatf("t4_stall%0d_grant", i), 64'(bus_i.grant_idx), 64'd1);
      check($sformatf("t4_stall%0d_rdy0", i), 64'(bus_i.in_ready[0]), 64'd0);
    end
    hold[1] = 1'b0;
    wait_obs("t4_count", 5, 40);
    check("t4_grant_a", 64'(grants.size() > 0 ? grants[0] : -1), 64'd1);
    check("t4_grant_b", 64'(grants.size() > 1 ? grants[1] : -1), 64'd0);
    for (int b = 0; b < 5 && b < obs.size(); b++)
      check($sformatf("t4_beat%0d", b), 64'(obs[b]), 64'((b < 4) ? mk(1, b, b == 3) : mk(0, 0, 1'b1)));

    // Reset mid-packet with two beats buffered; rr_ptr is 1 beforehand.
    obs.delete();
    obs_cyc.delete();
    grants.delete();
    grant_cyc.delete();
    bus_i.out_ready = 1'b0;
    base = acc_cnt[3];
    push_pkt(3, 5);
    n = 0;
    while (acc_cnt[3] - base < 2 && n < 30) begin
      step();
      n++;
    end
    step();
    step();
    check("t5_buffered", 64'(bus_i.out_valid), 64'd1);
    check("t5_full_rdy", 64'(bus_i.in_ready), 64'd0);
    push_pkt(0, 1);
    push_pkt(4, 1);
    rst = 1'b1;
    step();
    check("t5_rst_out_valid", 64'(bus_i.out_valid), 64'd0);
    check("t5_rst_locked",    64'(bus_i.locked),    64'd0);
    check("t5_rst_in_ready",  64'(bus_i.in_ready),  64'd0);
    check("t5_rst_grant",     64'(bus_i.grant_idx), 64'd0);
    rst = 1'b0;
    q[3].delete();
    obs.delete();
    obs_cyc.delete();
    grants.delete();
    grant_cyc.delete();
    bus_i.out_ready = 1'b1;
    wait_obs("t5_count", 2, 40);
    check("t5_grant_a", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);
    check("t5_grant_b", 64'(grants.size() > 1 ? grants[1] : -1), 64'd4);
    if (obs.size() >= 2) begin
      check("t5_beat0", 64'(obs[0]), 64'(mk(0, 0, 1'b1)));
      check("t5_beat1", 64'(obs[1]), 64'(mk(4, 0, 1'b1)));
    end
    for (int i = 0; i < 4; i++) step();
    check("t5_no_leftover", 64'(obs.size()), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
